// File: rtl/led_step_sequencer.sv
// Step sequencer fed by the LED blinker: every blink_in level change advances an
// 8-bit LED-bar pattern and a two-digit BCD count shown on two 7-segment digits.
module led_step_sequencer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       blink_in,
   input  logic [1:0] mode,
   input  logic       pause,
   output logic [7:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic       tick
);

   localparam logic [1:0] MODE_WALK_L = 2'd0;
   localparam logic [1:0] MODE_WALK_R = 2'd1;
   localparam logic [1:0] MODE_PING   = 2'd2;
   localparam logic [1:0] MODE_COUNT  = 2'd3;

   typedef enum logic {LEFT, RIGHT} dir_t;

   function automatic logic [7:0] seed(input logic [1:0] m);
      return (m == MODE_COUNT) ? 8'h00 : 8'h01;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Synchroniser chain plus one history flop behind it; the edge compares the
   // last synchronised sample with the one before, so the step lands SYNC_STAGES
   // edges after blink_in is first sampled.
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_last;
   logic                   blink_edge;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync_q    <= '0;
         sync_last <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], blink_in};
         sync_last <= sync_q[SYNC_STAGES-1];
      end
   end

   assign blink_edge = sync_q[SYNC_STAGES-1] ^ sync_last;

   logic [1:0] mode_q;
   logic       mode_change;
   logic       step;

   assign mode_change = (mode != mode_q);
   assign step        = blink_edge & ~pause & ~mode_change;

   dir_t       dir;
   dir_t       dir_nxt;
   logic [7:0] led_nxt;

   always_comb begin
      led_nxt = LEDR;
      dir_nxt = dir;
      case (mode)
         MODE_WALK_L: led_nxt = {LEDR[6:0], LEDR[7]};
         MODE_WALK_R: led_nxt = {LEDR[0], LEDR[7:1]};
         MODE_PING: begin
            if (dir == LEFT) begin
               if (LEDR == 8'h80) begin
                  led_nxt = 8'h40;
                  dir_nxt = RIGHT;
               end else begin
                  led_nxt = LEDR << 1;
               end
            end else begin
               if (LEDR == 8'h01) begin
                  led_nxt = 8'h02;
                  dir_nxt = LEFT;
               end else begin
                  led_nxt = LEDR >> 1;
               end
            end
         end
         default: led_nxt = LEDR + 8'd1;
      endcase
   end

   logic [3:0] ones, tens;
   logic [3:0] ones_nxt, tens_nxt;

   always_comb begin
      ones_nxt = ones + 4'd1;
      tens_nxt = tens;
      if (ones == 4'd9) begin
         ones_nxt = 4'd0;
         tens_nxt = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end
   end

   // A mode change wins over a coincident edge: that edge is dropped, not deferred.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         mode_q <= mode;
         LEDR   <= seed(mode);
         dir    <= LEFT;
         ones   <= 4'd0;
         tens   <= 4'd0;
         HEX0   <= 7'h40;
         HEX1   <= 7'h40;
         tick   <= 1'b0;
      end else begin
         mode_q <= mode;
         tick   <= step;
         HEX0   <= seg7(ones);
         HEX1   <= seg7(tens);
         if (mode_change) begin
            LEDR <= seed(mode);
            dir  <= LEFT;
         end else if (step) begin
            LEDR <= led_nxt;
            dir  <= dir_nxt;
         end
         if (step) begin
            ones <= ones_nxt;
            tens <= tens_nxt;
         end
      end
   end

endmodule

// File: tb/tb_led_step_sequencer.sv
// Bench for led_step_sequencer: constant-expectation vector table, hand-written
// corner sequences, and random traffic against a cycle-level behavioural model.
module tb_led_step_sequencer;

   localparam int S = 2;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       blink_in = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       pause = 1'b0;
   logic [7:0] LEDR;
   logic [6:0] HEX0, HEX1;
   logic       tick;

   led_step_sequencer #(.SYNC_STAGES(S)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .blink_in(blink_in), .mode(mode),
      .pause(pause), .LEDR(LEDR), .HEX0(HEX0), .HEX1(HEX1), .tick(tick)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: positions and counts as plain integers.
   int m_led, m_phase, m_cnt, m_hex0, m_hex1, m_tick;
   logic [1:0] m_modeq;
   logic bh [4];

   function automatic int pp_led(input int p);
      return (p < 8) ? (1 << p) : (1 << (14 - p));
   endfunction

   task automatic model_edge();
      logic e, mc, st;
      if (reset) begin
         m_led = (mode == 2'd3) ? 0 : 1;
         m_phase = 0;
         m_cnt = 0;
         m_hex0 = 'h40;
         m_hex1 = 'h40;
         m_tick = 0;
         m_modeq = mode;
         for (int i = 0; i < 4; i++) bh[i] = 1'b0;
      end else begin
         e  = bh[S-1] ^ bh[S];
         mc = (mode != m_modeq);
         st = e && !pause && !mc;
         m_hex0 = seg_tab[m_cnt % 10];
         m_hex1 = seg_tab[m_cnt / 10];
         if (mc) begin
            m_led = (mode == 2'd3) ? 0 : 1;
            m_phase = 0;
         end else if (st) begin
            case (mode)
               2'd0: m_led = (m_led * 2) % 256 + m_led / 128;
               2'd1: m_led = m_led / 2 + (m_led % 2) * 128;
               2'd2: begin
                  m_phase = (m_phase + 1) % 14;
                  m_led = pp_led(m_phase);
               end
               default: m_led = (m_led + 1) % 256;
            endcase
         end
         if (st) m_cnt = (m_cnt + 1) % 100;
         m_tick = st ? 1 : 0;
         m_modeq = mode;
         for (int i = 3; i > 0; i--) bh[i] = bh[i-1];
         bh[0] = blink_in;
      end
   endtask

   task automatic step_cycle();
      @(posedge CLOCK_50);
      model_edge();
      #1;
      cyc++;
      chk("model_ledr", LEDR, m_led);
      chk("model_hex0", HEX0, m_hex0);
      chk("model_hex1", HEX1, m_hex1);
      chk("model_tick", tick, m_tick);
   endtask

   task automatic toggles(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         blink_in = ~blink_in;
         repeat (gap) step_cycle();
      end
   endtask

   task automatic do_reset(input logic [1:0] m);
      mode = m;
      pause = 1'b0;
      blink_in = 1'b0;
      reset = 1'b1;
      repeat (2) step_cycle();
      reset = 1'b0;
   endtask

   typedef struct {
      bit         rst;
      logic [1:0] mode;
      bit         pause;
      int         ntog;
      int         gap;
      logic [7:0] exp_led;
      int         exp_cnt;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{0, 2'd0, 0,   9, 10, 8'h02,  9};
      vecs[1] = '{0, 2'd2, 0,   0,  4, 8'h01,  9};
      vecs[2] = '{0, 2'd2, 0,   7,  6, 8'h80, 16};
      vecs[3] = '{0, 2'd2, 0,   1,  6, 8'h40, 17};
      vecs[4] = '{0, 2'd2, 0,   6,  6, 8'h01, 23};
      vecs[5] = '{0, 2'd2, 0,   1,  6, 8'h02, 24};
      vecs[6] = '{0, 2'd3, 0,   0,  4, 8'h00, 24};
      vecs[7] = '{1, 2'd3, 0, 256,  4, 8'h00, 56};
      vecs[8] = '{0, 2'd3, 0,  44,  4, 8'h2C,  0};
      vecs[9] = '{0, 2'd3, 1,   5, 10, 8'h2C,  0};

      do_reset(2'd0);
      chk("reset_ledr", LEDR, 8'h01);
      chk("reset_hex0", HEX0, 7'h40);
      chk("reset_hex1", HEX1, 7'h40);
      chk("reset_tick", tick, 0);

      for (int v = 0; v < 10; v++) begin
         if (vecs[v].rst) do_reset(vecs[v].mode);
         mode = vecs[v].mode;
         pause = vecs[v].pause;
         if (vecs[v].ntog == 0) repeat (3) step_cycle();
         toggles(vecs[v].ntog, vecs[v].gap);
         chk($sformatf("vec%0d_ledr", v), LEDR, vecs[v].exp_led);
         chk($sformatf("vec%0d_hex0", v), HEX0, seg_tab[vecs[v].exp_cnt % 10]);
         chk($sformatf("vec%0d_hex1", v), HEX1, seg_tab[vecs[v].exp_cnt / 10]);
      end

      pause = 1'b0;
      toggles(1, 6);
      chk("unpause_ledr", LEDR, 8'h2D);
      chk("unpause_hex0", HEX0, 7'h79);

      // Edge arriving in the same cycle as a mode change is lost.
      do_reset(2'd0);
      toggles(3, 6);
      chk("msw_pre_ledr", LEDR, 8'h08);
      blink_in = ~blink_in;
      step_cycle();
      step_cycle();
      mode = 2'd3;
      step_cycle();
      chk("msw_ledr", LEDR, 8'h00);
      chk("msw_tick", tick, 0);
      repeat (5) step_cycle();
      chk("msw_after_ledr", LEDR, 8'h00);
      chk("msw_hex0", HEX0, 7'h30);
      chk("msw_hex1", HEX1, 7'h40);

      // Reset mid-run with a toggle in the reset cycle.
      do_reset(2'd3);
      toggles(42, 4);
      mode = 2'd0;
      repeat (3) step_cycle();
      toggles(5, 6);
      chk("mid_pre_ledr", LEDR, 8'h20);
      chk("mid_pre_hex1", HEX1, 7'h19);
      chk("mid_pre_hex0", HEX0, 7'h78);
      reset = 1'b1;
      blink_in = 1'b0;
      step_cycle();
      chk("mid_rst_ledr", LEDR, 8'h01);
      chk("mid_rst_hex0", HEX0, 7'h40);
      chk("mid_rst_hex1", HEX1, 7'h40);
      chk("mid_rst_tick", tick, 0);
      reset = 1'b0;
      repeat (6) step_cycle();
      chk("mid_post_ledr", LEDR, 8'h01);
      chk("mid_post_hex0", HEX0, 7'h40);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) begin
            reset = 1'b1;
            blink_in = 1'b0;
         end else begin
            reset = 1'b0;
            if ($urandom_range(2) == 0) blink_in = ~blink_in;
         end
         if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
         pause = ($urandom_range(3) == 0);
         step_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
